// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: owns the RX datapath config, supervises frames with a timeout and
// buffers received bytes in a FWFT FIFO. Optional IRQ output: define UART_RX_CTRL_IRQ_EN.
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int TO_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [5:0]             cfg_prescale,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_typ,
  output logic [5:0]             prescale,
  output logic                   par_en,
  output logic                   par_typ,
  output logic                   cfg_pending,
  input  logic                   rx_in,
  input  logic                   rx_data_valid,
  input  logic [DATA_W-1:0]      rx_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_to,
  input  logic                   err_clr
`ifdef UART_RX_CTRL_IRQ_EN
  ,
  input  logic [$clog2(DEPTH):0] irq_thresh,
  output logic                   irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TO_BITS * 32 + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  function automatic logic prescale_legal(input logic [5:0] ps);
    return (ps == 6'd8) || (ps == 6'd16) || (ps == 6'd32);
  endfunction

  // Last cycle index of a frame before it is declared timed out.
  function automatic logic [TW-1:0] timeout_last(input logic [5:0] ps);
    return TW'(TO_BITS * int'(ps) - 1);
  endfunction

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   to_cnt;
  logic [TW-1:0]   to_cnt_nxt;
  logic            rx_in_q;
  logic            start_edge;
  logic            apply_cfg;
  logic            to_hit;

  logic [5:0]      pend_prescale;
  logic            pend_par_en;
  logic            pend_par_typ;
  logic            cfg_ok;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic            overrun_nxt;
  logic            frame_to_nxt;

  // Stage: line history and start-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_in_q <= 1'b1;
    end else begin
      rx_in_q <= rx_in;
    end
  end

  assign start_edge = rx_in_q & ~rx_in;

  // Stage: frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    apply_cfg  = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        apply_cfg = cfg_pending;
        if (start_edge) begin
          state_nxt  = FRAME;
          to_cnt_nxt = '0;
        end
      end
      FRAME: begin
        to_cnt_nxt = to_cnt + TW'(1);
        if (rx_data_valid) begin
          state_nxt = IDLE;
        end else if (to_cnt == timeout_last(prescale)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FRAME);

  // Stage: configuration (pending copy is data, only its flag is reset)
  assign cfg_ok = cfg_wr & prescale_legal(cfg_prescale);

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      pend_prescale <= cfg_prescale;
      pend_par_en   <= cfg_par_en;
      pend_par_typ  <= cfg_par_typ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale    <= 6'd8;
      par_en      <= 1'b0;
      par_typ     <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (apply_cfg) begin
        prescale <= pend_prescale;
        par_en   <= pend_par_en;
        par_typ  <= pend_par_typ;
      end
      if (cfg_ok) begin
        cfg_pending <= 1'b1;
      end else if (apply_cfg) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Stage: FIFO (pop is resolved before push, so a full FIFO can accept on a pop)
  always_comb begin
    full      = (count == DEPTH_C);
    pop       = out_valid & out_ready;
    push_ok   = rx_data_valid & (~full | pop);
    drop      = rx_data_valid & full & ~pop;
    count_nxt = count + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

  assign fifo_count = count;
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  // Stage: sticky status, a set event beats a same-cycle clear
  always_comb begin
    overrun_nxt  = drop   ? 1'b1 : (err_clr ? 1'b0 : overrun);
    frame_to_nxt = to_hit ? 1'b1 : (err_clr ? 1'b0 : frame_to);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      frame_to <= 1'b0;
    end else begin
      overrun  <= overrun_nxt;
      frame_to <= frame_to_nxt;
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  // Evaluated on next-state values so irq lines up with the flags it reflects.
  logic irq_nxt;

  always_comb begin
    irq_nxt = ((count_nxt >= irq_thresh) && (irq_thresh != '0))
              || overrun_nxt || frame_to_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios plus randomized traffic against
// a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int TO_BITS = 12;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr = 1'b0;
  logic [5:0]        cfg_prescale = 6'd8;
  logic              cfg_par_en = 1'b0;
  logic              cfg_par_typ = 1'b0;
  logic [5:0]        prescale;
  logic              par_en;
  logic              par_typ;
  logic              cfg_pending;
  logic              rx_in = 1'b1;
  logic              rx_data_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     fifo_count;
  logic              busy;
  logic              overrun;
  logic              frame_to;
  logic              err_clr = 1'b0;
`ifdef UART_RX_CTRL_IRQ_EN
  logic [CW-1:0]     irq_thresh = '0;
  logic              irq;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_BITS(TO_BITS)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_typ(cfg_par_typ),
    .prescale(prescale), .par_en(par_en), .par_typ(par_typ), .cfg_pending(cfg_pending),
    .rx_in(rx_in), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy), .overrun(overrun), .frame_to(frame_to),
    .err_clr(err_clr)
`ifdef UART_RX_CTRL_IRQ_EN
    , .irq_thresh(irq_thresh), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: frame tracked as elapsed cycles, FIFO as a queue.
  logic [5:0]        m_ps = 6'd8;
  bit                m_pe = 0, m_pt = 0;
  bit                m_pend = 0;
  logic [5:0]        m_pend_ps = 6'd8;
  bit                m_pend_pe = 0, m_pend_pt = 0;
  bit                m_in_frame = 0;
  int                m_elapsed = 0;
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovr = 0, m_to = 0;
  bit                m_prev_rx = 1;

  always @(posedge clk) begin : model
    bit start, pop, legal, apply, tmo, ovr_set;
    if (rst) begin
      m_ps = 6'd8; m_pe = 0; m_pt = 0; m_pend = 0;
      m_in_frame = 0; m_elapsed = 0; m_q.delete();
      m_ovr = 0; m_to = 0; m_prev_rx = 1;
    end else begin
      start   = m_prev_rx && !rx_in;
      pop     = (m_q.size() > 0) && out_ready;
      legal   = cfg_wr && (cfg_prescale inside {6'd8, 6'd16, 6'd32});
      apply   = !m_in_frame && m_pend;
      tmo     = m_in_frame && !rx_data_valid && (m_elapsed + 1 == TO_BITS * int'(m_ps));
      ovr_set = 0;
      if (pop) void'(m_q.pop_front());
      if (rx_data_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(rx_data);
        else ovr_set = 1;
      end
      if (!m_in_frame) begin
        m_in_frame = start;
        m_elapsed  = 0;
      end else if (rx_data_valid || tmo) begin
        m_in_frame = 0;
      end else begin
        m_elapsed++;
      end
      m_ovr = ovr_set ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
      m_to  = tmo     ? 1'b1 : (err_clr ? 1'b0 : m_to);
      if (apply) begin
        m_ps = m_pend_ps; m_pe = m_pend_pe; m_pt = m_pend_pt;
      end
      if (legal) begin
        m_pend = 1; m_pend_ps = cfg_prescale; m_pend_pe = cfg_par_en; m_pend_pt = cfg_par_typ;
      end else if (apply) begin
        m_pend = 0;
      end
      m_prev_rx = rx_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [5:0] ps, input bit pe, input bit pt);
    cfg_wr = 1; cfg_prescale = ps; cfg_par_en = pe; cfg_par_typ = pt;
    tick();
    cfg_wr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if ({prescale, par_en, par_typ, cfg_pending} !== {6'd8, 3'b000}) begin
      errors++;
      $display("FAIL reset_cfg: got ps=%0d pe=%0b pt=%0b pend=%0b, expected 8/0/0/0",
               prescale, par_en, par_typ, cfg_pending);
    end
    checks++;
    if ({out_valid, out_data, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_fifo: got valid=%0b data=%0h count=%0d, expected all 0",
               out_valid, out_data, fifo_count);
    end
    checks++;
    if ({busy, overrun, frame_to} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got busy/ovr/to=%b, expected 000", {busy, overrun, frame_to});
    end
  endtask

  task automatic test_cfg_idle();
    write_cfg(6'd16, 1, 1);
    checks++;
    if (cfg_pending !== 1'b1 || prescale !== 6'd8) begin
      errors++;
      $display("FAIL cfg_idle_pending: got pend=%0b ps=%0d, expected 1/8", cfg_pending, prescale);
    end
    tick();
    checks++;
    if ({prescale, par_en, par_typ, cfg_pending} !== {6'd16, 3'b110}) begin
      errors++;
      $display("FAIL cfg_idle_apply: got ps=%0d pe=%0b pt=%0b pend=%0b, expected 16/1/1/0",
               prescale, par_en, par_typ, cfg_pending);
    end
    write_cfg(6'd12, 0, 0);
    checks++;
    if (cfg_pending !== 1'b0 || prescale !== 6'd16) begin
      errors++;
      $display("FAIL cfg_illegal: got pend=%0b ps=%0d, expected 0/16", cfg_pending, prescale);
    end
    write_cfg(6'd8, 0, 0);
    tick();
  endtask

  task automatic test_cfg_in_frame();
    rx_in = 0;
    tick();
    rx_in = 1;
    write_cfg(6'd32, 0, 0);
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || prescale !== 6'd8 || cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL cfg_frame_hold: got busy=%0b ps=%0d pend=%0b, expected 1/8/1",
               busy, prescale, cfg_pending);
    end
    rx_data_valid = 1; rx_data = 8'hA5;
    tick();
    rx_data_valid = 0;
    checks++;
    if (busy !== 1'b0 || prescale !== 6'd8 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL cfg_frame_end: got busy=%0b ps=%0d count=%0d, expected 0/8/1",
               busy, prescale, fifo_count);
    end
    tick();
    checks++;
    if (prescale !== 6'd32 || cfg_pending !== 1'b0 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL cfg_frame_apply: got ps=%0d pend=%0b data=%0h, expected 32/0/a5",
               prescale, cfg_pending, out_data);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    write_cfg(6'd8, 0, 0);
    tick();
  endtask

  task automatic test_timeout();
    rx_in = 0;
    tick();
    rx_in = 1;
    repeat (95) tick();
    checks++;
    if (busy !== 1'b1 || frame_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy=%0b to=%0b at 95 cycles, expected 1/0", busy, frame_to);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || frame_to !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got busy=%0b to=%0b at 96 cycles, expected 0/1", busy, frame_to);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (frame_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got to=%0b, expected 0", frame_to);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      rx_data_valid = 1; rx_data = DATA_W'(i);
      tick();
    end
    rx_data_valid = 0;
    checks++;
    if (fifo_count !== CW'(8) || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_full: got count=%0d ovr=%0b, expected 8/1", fifo_count, overrun);
    end
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
        errors++;
        $display("FAIL overrun_drain: got valid=%0b data=%0h, expected 1/%0h", out_valid, out_data, i);
      end
      tick();
    end
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_empty: got valid=%0b, expected 0", out_valid);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      rx_data_valid = 1; rx_data = DATA_W'(8'h10 + i);
      tick();
    end
    out_ready = 1; rx_data = 8'h99;
    tick();
    rx_data_valid = 0;
    checks++;
    if (fifo_count !== CW'(8) || overrun !== 1'b0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovr=%0b head=%0h, expected 8/0/11",
               fifo_count, overrun, out_data);
    end
    repeat (7) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      errors++;
      $display("FAIL full_push_pop_last: got valid=%0b data=%0h, expected 1/99", out_valid, out_data);
    end
    tick();
    out_ready = 0;
  endtask

  task automatic test_rst_mid_frame();
    write_cfg(6'd16, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      rx_data_valid = 1; rx_data = DATA_W'($urandom_range(0, 255));
      tick();
    end
    rx_data_valid = 0;
    rx_in = 0;
    tick();
    rx_in = 1;
    write_cfg(6'd32, 0, 1);
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== '0 || busy !== 1'b0 || prescale !== 6'd8) begin
      errors++;
      $display("FAIL rst_mid_frame: got valid=%0b count=%0d busy=%0b ps=%0d, expected 0/0/0/8",
               out_valid, fifo_count, busy, prescale);
    end
    tick();
    checks++;
    if (cfg_pending !== 1'b0 || prescale !== 6'd8 || par_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard_pending: got pend=%0b ps=%0d pe=%0b, expected 0/8/0",
               cfg_pending, prescale, par_en);
    end
  endtask

  task automatic test_random();
    logic [5:0] ps_tab [5];
    int vld_pm;
    ps_tab[0] = 6'd8; ps_tab[1] = 6'd16; ps_tab[2] = 6'd32; ps_tab[3] = 6'd12; ps_tab[4] = 6'd0;
    rst = 1;
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      vld_pm        = ((cyc / 400) % 2 == 1) ? 3 : 250;
      rx_in         = ($urandom_range(0, 9) != 0);
      rx_data_valid = ($urandom_range(0, 999) < vld_pm);
      rx_data       = DATA_W'($urandom);
      out_ready     = $urandom_range(0, 1) == 1;
      cfg_wr        = ($urandom_range(0, 19) == 0);
      cfg_prescale  = ps_tab[$urandom_range(0, 4)];
      cfg_par_en    = $urandom_range(0, 1) == 1;
      cfg_par_typ   = $urandom_range(0, 1) == 1;
      err_clr       = ($urandom_range(0, 29) == 0);
      rst           = ($urandom_range(0, 599) == 0);
      tick();
      checks++;
      if ({prescale, par_en, par_typ, cfg_pending, fifo_count, out_valid, busy, overrun, frame_to} !==
          {m_ps, m_pe, m_pt, m_pend, CW'(m_q.size()), m_q.size() > 0, m_in_frame, m_ovr, m_to}) begin
        errors++;
        $display("FAIL random_ctrl cyc %0d: got ps=%0d pe=%0b pt=%0b pend=%0b cnt=%0d v=%0b busy=%0b ovr=%0b to=%0b, expected ps=%0d pe=%0b pt=%0b pend=%0b cnt=%0d busy=%0b ovr=%0b to=%0b",
                 cyc, prescale, par_en, par_typ, cfg_pending, fifo_count, out_valid, busy, overrun,
                 frame_to, m_ps, m_pe, m_pt, m_pend, m_q.size(), m_in_frame, m_ovr, m_to);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (out_data !== m_q[0]) begin
          errors++;
          $display("FAIL random_head cyc %0d: got %0h, expected %0h", cyc, out_data, m_q[0]);
        end
      end
    end
    rst = 0; cfg_wr = 0; rx_data_valid = 0; out_ready = 0; err_clr = 0; rx_in = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_cfg_idle();
    test_cfg_in_frame();
    test_timeout();
    test_overrun();
    test_full_push_pop();
    test_rst_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART RX datapath. It owns the datapath configuration (prescale, parity enable, parity type) and applies updates only while the line is idle. It supervises each frame with a timeout and buffers every data_valid byte into a first-word-fall-through FIFO with a valid/ready read port. It reports overrun, frame-timeout and error status as sticky flags.

Parameters:
DATA_W, 8, stored data width (rx_data bits kept per frame)
DEPTH, 8, FIFO entries; power of two, >= 2
TO_BITS, 12, frame timeout in bit-times (timeout cycles = TO_BITS * active prescale)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
cfg_wr  in  1  one-cycle strobe: latch cfg_* into pending config
cfg_prescale  in  6  requested prescale (8, 16 or 32; others ignored, no latch)
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type
prescale  out  6  active prescale to RX datapath
par_en  out  1  active parity enable to RX datapath
par_typ  out  1  active parity type to RX datapath
cfg_pending  out  1  pending config not yet applied
rx_in  in  1  serial line (already synchronised)
rx_data_valid  in  1  one-cycle pulse from RX datapath: frame accepted
rx_data  in  DATA_W  received data, valid with rx_data_valid
out_valid  out  1  FIFO non-empty
out_data  out  DATA_W  FIFO head, valid while out_valid
out_ready  in  1  consumer accepts head when out_valid && out_ready
fifo_count  out  clog2(DEPTH)+1  occupancy
busy  out  1  FSM in FRAME
overrun  out  1  sticky: push dropped because FIFO full
frame_to  out  1  sticky: frame timeout
err_clr  in  1  clears overrun and frame_to

Behaviour:
- Reset values: prescale=8, par_en=0, par_typ=0, cfg_pending=0, FIFO empty, out_valid=0, out_data=0, fifo_count=0, busy=0, overrun=0, frame_to=0, FSM=IDLE, rx_in history register=1.
- Falling-edge detect: rx_in_q <= rx_in each cycle. A start edge occurs when rx_in_q=1 and rx_in=0.
- FSM IDLE:
  - If cfg_pending, copy pending into the active outputs on this cycle and clear cfg_pending. Start-edge detection is still evaluated in the same cycle.
  - On a start edge, go to FRAME, clear the timeout counter, busy=1 from the next cycle.
- FSM FRAME:
  - The timeout counter increments each cycle.
  - On rx_data_valid, go to IDLE.
  - On counter == TO_BITS*prescale-1 without rx_data_valid, set frame_to and go to IDLE.
  - If both occur in the same cycle, rx_data_valid wins: byte pushed, no frame_to.
  - Active config never changes in FRAME.
- cfg_wr:
  - Overwrites pending config and sets cfg_pending.
  - Legal in any state. The last write before IDLE wins.
  - cfg_wr in IDLE applies on the following cycle, unless a start edge moves the FSM to FRAME first.
- rx_data_valid outside FRAME is still pushed; a spurious pulse is not an error.
- FIFO:
  - Push on rx_data_valid. Pop on out_valid && out_ready.
  - out_data is the head, combinational from storage; zero when empty is not required.
  - Push while full: data dropped, overrun set, contents unchanged.
  - Simultaneous push and pop while full: pop first, push accepted, no overrun, count unchanged.
  - Simultaneous push and pop while empty: push only; out_valid asserts next cycle.
  - Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Sticky flags: err_clr clears them. If a set event and err_clr occur in the same cycle, set wins.
- rst mid-frame: FSM to IDLE, FIFO flushed, pending config discarded, active config back to defaults.

Optional Feature:
UART_RX_CTRL_IRQ_EN
- Defined: adds port irq_thresh (in, clog2(DEPTH)+1) and irq (out, 1).
  - irq is registered, reset 0.
  - irq = (fifo_count >= irq_thresh && irq_thresh != 0) || overrun || frame_to, evaluated on next-state values so irq has no extra cycle lag vs the flags.
- Undefined: neither port exists; no logic.

Test Plan:
- After reset, cfg_wr with prescale=16, par_en=1, par_typ=1 while idle -> outputs 16/1/1 one cycle later; cfg_pending high exactly 1 cycle.
- Start edge, then cfg_wr prescale=32 during FRAME -> active prescale stays 8 until rx_data_valid; becomes 32 the cycle after the return to IDLE.
- Start edge, no rx_data_valid, prescale=8, TO_BITS=12 -> frame_to asserts after 96 FRAME cycles; busy drops same edge. err_clr -> frame_to=0.
- 9 pushes (0x01..0x09), DEPTH=8, out_ready=0 -> fifo_count=8, overrun=1. Draining then yields 0x01..0x08 in order.
- FIFO full with out_ready=1 and rx_data_valid=1 same cycle -> count stays 8, no overrun, the new byte appears last.
- rst asserted mid-frame with 3 entries buffered -> next cycle: out_valid=0, fifo_count=0, busy=0, prescale=8.
